// File: rtl/wshb_arbiter_pkg.sv
// wshb_arbiter_pkg
//   Shared types and constants for the Wishbone N:1 arbiter.
//   - arb_state_e     : arbiter FSM state (idle / bus owned)
//   - ARB_TIMEOUT_DEF : default stall limit of the optional watchdog
//   - arb_idx_w       : index width helper (1 bit minimum)
package wshb_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEF = 1024;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wshb_rr_picker.sv
// wshb_rr_picker
//   Combinational round-robin search. Looks upward from (i_last+1) mod N
//   and returns the first active requester.
//   Ports:
//     i_req   [N-1:0]  request vector
//     i_last  [IW-1:0] index of the previous owner
//     o_pick  [N-1:0]  one-hot winner (zero when no request)
//     o_valid          at least one request present
module wshb_rr_picker
  import wshb_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = arb_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_pick,
  output logic          o_valid
);

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(i_last) + k) % N;
      if (!o_valid && i_req[idx]) begin
        o_pick[idx] = 1'b1;
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter.sv
// wshb_arbiter
//   Round-robin N:1 Wishbone bus arbiter. One master owns the slave port
//   for as long as it holds m_cyc; bursts are never preempted. Ownership
//   is granted one cycle after a request is seen in IDLE.
//   Optional feature: define WSHB_ARB_TIMEOUT_EN to build a stall watchdog
//   that terminates a stalled strobe with m_err after TIMEOUT cycles.
//   Ports:
//     sys_clk, sys_rst_n            clock, async active-low reset
//     m_cyc/m_stb/m_we/m_adr/m_sel/m_dat_ms   per-master request side
//     m_ack/m_err                   per-master termination (owner only)
//     m_dat_sm                      shared read data
//     s_cyc/s_stb/s_we/s_adr/s_sel/s_dat_ms   slave request side
//     s_ack/s_err/s_dat_sm          slave response
//     grant                         one-hot current owner, zero when idle
module wshb_arbiter
  import wshb_arbiter_pkg::*;
#(
  parameter int NMASTERS   = 3,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst_n,
  input  logic [NMASTERS-1:0]                      m_cyc,
  input  logic [NMASTERS-1:0]                      m_stb,
  input  logic [NMASTERS-1:0]                      m_we,
  input  logic [NMASTERS-1:0][ADDR_W-1:0]          m_adr,
  input  logic [NMASTERS-1:0][DATA_BYTES-1:0]      m_sel,
  input  logic [NMASTERS-1:0][8*DATA_BYTES-1:0]    m_dat_ms,
  output logic [NMASTERS-1:0]                      m_ack,
  output logic [NMASTERS-1:0]                      m_err,
  output logic [8*DATA_BYTES-1:0]                  m_dat_sm,
  output logic                                     s_cyc,
  output logic                                     s_stb,
  output logic                                     s_we,
  output logic [ADDR_W-1:0]                        s_adr,
  output logic [DATA_BYTES-1:0]                    s_sel,
  output logic [8*DATA_BYTES-1:0]                  s_dat_ms,
  input  logic                                     s_ack,
  input  logic                                     s_err,
  input  logic [8*DATA_BYTES-1:0]                  s_dat_sm,
  output logic [NMASTERS-1:0]                      grant
);

  localparam int IW = arb_idx_w(NMASTERS);
  localparam int DW = 8 * DATA_BYTES;

  arb_state_e          r_state, w_state_nxt;
  logic [NMASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]       r_last,  w_last_nxt;
  logic [IW-1:0]       r_own,   w_own_nxt;

  logic [NMASTERS-1:0] w_pick;
  logic                w_pick_vld;
  logic [IW-1:0]       w_pick_idx;

  // owner's request signals, AND-OR muxed by the one-hot grant so that a
  // zero grant (idle or in reset) yields an all-zero slave request
  logic                w_mux_cyc, w_mux_stb, w_mux_we;
  logic [ADDR_W-1:0]   w_mux_adr;
  logic [DATA_BYTES-1:0] w_mux_sel;
  logic [DW-1:0]       w_mux_dat;
  logic                w_tmo;

  wshb_rr_picker #(.N(NMASTERS), .IW(IW)) u_pick (
    .i_req   (m_cyc),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NMASTERS; i++)
      if (w_pick[i]) w_pick_idx = IW'(i);
  end

  always_comb begin
    w_mux_cyc = 1'b0;
    w_mux_stb = 1'b0;
    w_mux_we  = 1'b0;
    w_mux_adr = '0;
    w_mux_sel = '0;
    w_mux_dat = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (r_grant[i]) begin
        w_mux_cyc = w_mux_cyc | m_cyc[i];
        w_mux_stb = w_mux_stb | m_stb[i];
        w_mux_we  = w_mux_we  | m_we[i];
        w_mux_adr = w_mux_adr | m_adr[i];
        w_mux_sel = w_mux_sel | m_sel[i];
        w_mux_dat = w_mux_dat | m_dat_ms[i];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IW'(NMASTERS - 1);  // master 0 wins the first search
      r_own   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_own   <= w_own_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_own_nxt   = r_own;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_OWNED;
          w_grant_nxt = w_pick;
          w_own_nxt   = w_pick_idx;
        end
      end
      ST_OWNED: begin
        // release on m_cyc drop even with a strobe outstanding
        if (!w_mux_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = r_own;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    grant    = r_grant;
    s_cyc    = w_mux_cyc;
    s_stb    = w_mux_stb & ~w_tmo;
    s_we     = w_mux_we;
    s_adr    = w_mux_adr;
    s_sel    = w_mux_sel;
    s_dat_ms = w_mux_dat;
    m_ack    = r_grant & {NMASTERS{s_ack}};
    m_err    = r_grant & {NMASTERS{s_err | w_tmo}};
    m_dat_sm = s_dat_sm;
  end

`ifdef WSHB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_stall;
  logic          w_stalled;

  assign w_stalled = (r_state == ST_OWNED) && w_mux_stb && !s_ack && !s_err;
  // fires on the TIMEOUT-th consecutive stalled cycle
  assign w_tmo     = w_stalled && (r_stall == CW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_stall <= '0;
    else if (r_state != ST_OWNED || w_state_nxt != ST_OWNED ||
             s_ack || s_err || w_tmo)
      r_stall <= '0;
    else if (w_stalled)
      r_stall <= r_stall + 1'b1;
  end
`else
  // TIMEOUT has no effect without the watchdog
  assign w_tmo = (TIMEOUT == 0) & 1'b0;
`endif

endmodule
